// File: rtl/cs_trim_sequencer.sv
// cs_trim_sequencer
// Successive-approximation trim of a current-source code. For each trial code
// the sequencer waits SETTLE_CYC cycles, counts oscillator edges over a window
// of total_count+1 cycles, then keeps or clears the trial bit (MSB first)
// depending on whether the measured count exceeds target_count.
//
// Optional feature: define CS_TRIM_TOL_EN to add the tol input. A trial whose
// count lands within +/-tol of the target ends the run early with early=1.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst_n         asynchronous active-low reset
//   start         begin a trim run (accepted only in IDLE)
//   total_count   measurement window length minus one (cycles)
//   osc_edge      one-cycle pulse per oscillator edge, synchronous to clk
//   target_count  desired edge count per window
//   tol           (CS_TRIM_TOL_EN only) early-exit tolerance
//   trim_code     code driven to the current source
//   meas_count    edge count of the most recent completed window
//   busy          high while a run is in SETTLE/MEASURE/DECIDE
//   done          one-cycle completion pulse
//   early         run ended on a tolerance match
//
// state   | meaning
// IDLE    | waiting for start; outputs hold last result
// SETTLE  | SETTLE_CYC cycles for the current source to settle
// MEASURE | count osc_edge over total_count+1 cycles
// DECIDE  | keep/clear trial bit, pick next bit or finish
// DONE    | one-cycle done pulse, then back to IDLE

module cs_trim_sequencer #(
    parameter int CODE_W     = 6,
    parameter int CNT_W      = 12,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        total_count,
    input  logic              osc_edge,
    input  logic [CNT_W-1:0]  target_count,
`ifdef CS_TRIM_TOL_EN
    input  logic [3:0]        tol,
`endif
    output logic [CODE_W-1:0] trim_code,
    output logic [CNT_W-1:0]  meas_count,
    output logic              busy,
    output logic              done,
    output logic              early
);

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic [CNT_W-1:0]   meas_nxt;
    logic [IDX_W-1:0]   bit_idx, idx_nxt;
    logic [7:0]         settle_cnt, settle_nxt;
    logic [7:0]         win_cnt, win_nxt;
    logic [CNT_W-1:0]   acc, acc_nxt, acc_sum;
    logic               within_tol;

`ifdef CS_TRIM_TOL_EN
    logic               early_q, early_nxt;
    logic [CNT_W-1:0]   diff;

    assign diff       = (meas_count >= target_count) ? (meas_count - target_count)
                                                     : (target_count - meas_count);
    assign within_tol = (diff <= CNT_W'(tol));
    assign early      = early_q;
`else
    assign within_tol = 1'b0;
    assign early      = 1'b0;
`endif

    // Saturating edge accumulation: stays at all-ones instead of wrapping.
    assign acc_sum = (osc_edge && (acc != '1)) ? (acc + 1'b1) : acc;

    assign busy = (state == SETTLE) || (state == MEASURE) || (state == DECIDE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt  = state;
        code_nxt   = trim_code;
        meas_nxt   = meas_count;
        idx_nxt    = bit_idx;
        settle_nxt = settle_cnt;
        win_nxt    = win_cnt;
        acc_nxt    = acc;
`ifdef CS_TRIM_TOL_EN
        early_nxt  = early_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt            = IDX_W'(CODE_W - 1);
                    code_nxt           = '0;
                    code_nxt[CODE_W-1] = 1'b1;
                    settle_nxt         = 8'(SETTLE_CYC - 1);
`ifdef CS_TRIM_TOL_EN
                    early_nxt          = 1'b0;
`endif
                    state_nxt          = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    win_nxt   = total_count;
                    acc_nxt   = '0;
                    state_nxt = MEASURE;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            MEASURE: begin
                // Last window cycle still counts its edge before the copy out.
                if (win_cnt == '0) begin
                    meas_nxt  = acc_sum;
                    state_nxt = DECIDE;
                end else begin
                    win_nxt = win_cnt - 1'b1;
                    acc_nxt = acc_sum;
                end
            end
            DECIDE: begin
                if (within_tol) begin
`ifdef CS_TRIM_TOL_EN
                    early_nxt = 1'b1;
`endif
                    state_nxt = DONE;
                end else begin
                    if (meas_count > target_count)
                        code_nxt[bit_idx] = 1'b0;
                    if (bit_idx == '0) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt           = bit_idx - 1'b1;
                        code_nxt[idx_nxt] = 1'b1;
                        settle_nxt        = 8'(SETTLE_CYC - 1);
                        state_nxt         = SETTLE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            trim_code  <= '0;
            meas_count <= '0;
            bit_idx    <= IDX_W'(CODE_W - 1);
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
`ifdef CS_TRIM_TOL_EN
            early_q    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            trim_code  <= code_nxt;
            meas_count <= meas_nxt;
            bit_idx    <= idx_nxt;
            settle_cnt <= settle_nxt;
            win_cnt    <= win_nxt;
            acc        <= acc_nxt;
`ifdef CS_TRIM_TOL_EN
            early_q    <= early_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cs_trim_sequencer.sv
module tb_cs_trim_sequencer;

    localparam int SETTLE = 4;
`ifdef CS_TRIM_TOL_EN
    localparam int TOL_BUILD = 1;
`else
    localparam int TOL_BUILD = 0;
`endif

    typedef struct {
        int code;
        int meas;
        int cyc;
        int early;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  total_count = 8'd99;
    logic        osc_edge = 1'b0;
    logic [11:0] target_count = 12'd50;
    logic [5:0]  trim_code;
    logic [11:0] meas_count;
    logic        busy, done, early;

    logic        sat_start = 1'b0;
    logic [7:0]  sat_total = 8'd255;
    logic [7:0]  sat_target = 8'd254;
    logic [5:0]  sat_code;
    logic [7:0]  sat_meas;
    logic        sat_busy, sat_done, sat_early;

`ifdef CS_TRIM_TOL_EN
    logic [3:0]  tol = 4'd0;
`endif

    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    exp_t  sb[$];

    always #5 clk = ~clk;

    cs_trim_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .total_count  (total_count),
        .osc_edge     (osc_edge),
        .target_count (target_count),
`ifdef CS_TRIM_TOL_EN
        .tol          (tol),
`endif
        .trim_code    (trim_code),
        .meas_count   (meas_count),
        .busy         (busy),
        .done         (done),
        .early        (early)
    );

    cs_trim_sequencer #(.CNT_W(8)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (sat_start),
        .total_count  (sat_total),
        .osc_edge     (1'b1),
        .target_count (sat_target),
`ifdef CS_TRIM_TOL_EN
        .tol          (tol),
`endif
        .trim_code    (sat_code),
        .meas_count   (sat_meas),
        .busy         (sat_busy),
        .done         (sat_done),
        .early        (sat_early)
    );

    // Oscillator model: 2*code edges per window. Phase restarts whenever the
    // code changes (start of each SETTLE); edges land on the window cycles.
    initial begin
        int          phase;
        logic [5:0]  prev;
        phase = 0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (trim_code !== prev) phase = 0;
            else if (phase < 10000) phase++;
            prev = trim_code;
            osc_edge = (phase >= SETTLE) && (phase < SETTLE + 2 * int'(trim_code));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for done (counting busy cycles from the current cycle), then pops
    // the scoreboard and compares the result.
    task automatic wait_done(input string tag);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 0;
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy === 1'b1) cyc++;
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_code"},  32'(trim_code), 32'(e.code));
            check({tag, "_meas"},  32'(meas_count), 32'(e.meas));
            check({tag, "_cycles"}, 32'(cyc), 32'(e.cyc));
            check({tag, "_early"}, 32'(early), 32'(e.early));
            check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    task automatic run_main(input string tag, input logic [11:0] tgt, input exp_t e);
        target_count = tgt;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        int   dc0;
        int   cyc;
        bit   seen;

        #1;
        check("rst_code",  32'(trim_code), 32'd0);
        check("rst_meas",  32'(meas_count), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_early", 32'(early), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_main("t50",   12'd50,   '{25, 50,  630, TOL_BUILD});
        run_main("t0",    12'd0,    '{0,  2,   630, 0});
        run_main("t4095", 12'd4095, '{63, 100, 630, 0});

        repeat (20) @(posedge clk);
        #1;
        check("idle_hold_code", 32'(trim_code), 32'd63);
        check("idle_hold_meas", 32'(meas_count), 32'd100);
        check("idle_busy", 32'(busy), 32'd0);

        // Abort during the third MEASURE (cycles 214..313 after acceptance).
        target_count = 12'd50;
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_code",  32'(trim_code), 32'd0);
        check("mid_rst_meas",  32'(meas_count), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_early", 32'(early), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt), 32'(dc0));
        run_main("after_rst", 12'd50, '{25, 50, 630, TOL_BUILD});

        // start ignored while busy and while in DONE; accepted in the IDLE after.
        dc0 = done_cnt;
        target_count = 12'd50;
        sb.push_back('{25, 50, 630, TOL_BUILD});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            wait_done("busy_start");
            begin
                repeat (100) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (400) @(negedge clk);
                start = 1'b1;
            end
        join
        check("idle_after_done_busy", 32'(busy), 32'd0);
        sb.push_back('{25, 50, 630, TOL_BUILD});
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        wait_done("held_start");
        repeat (3) @(negedge clk);
        check("one_done_per_start", 32'(done_cnt - dc0), 32'd2);

        // Saturating counter on the CNT_W=8 instance with osc_edge tied high.
        @(negedge clk);
        sat_start = 1'b1;
        @(posedge clk); #1;
        sat_start = 1'b0;
        cyc  = 0;
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            if (sat_done === 1'b1) begin
                seen = 1;
                break;
            end
            if (sat_busy === 1'b1) cyc++;
            @(posedge clk); #1;
        end
        check("sat_done_seen", 32'(seen), 32'd1);
        check("sat_meas",   32'(sat_meas), 32'd255);
        check("sat_code",   32'(sat_code), 32'd0);
        check("sat_cycles", 32'(cyc), 32'd1566);

`ifdef CS_TRIM_TOL_EN
        tol = 4'd2;
        run_main("tol_early", 12'd33, '{16, 32, 210, 1});
        tol = 4'd0;
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_trim_sequencer.md
CS_TRIM_SEQUENCER -- requirements
Module: cs_trim_sequencer

Interface
REQ-001 Parameter CODE_W, default 6, width of the current-source trim code and number of search iterations.
REQ-002 Parameter CNT_W, default 12, width of the oscillation edge counter and target.
REQ-003 Parameter SETTLE_CYC, default 4, clk cycles waited after each code change before measuring; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  request a trim run; sampled only in IDLE.
REQ-007 total_count  input  8  measurement window length minus one, in clk cycles.
REQ-008 osc_edge  input  1  one-cycle pulse per oscillator edge, already synchronized to clk.
REQ-009 target_count  input  CNT_W  desired edge count per window.
REQ-010 trim_code  output  CODE_W  code driven to the current source.
REQ-011 meas_count  output  CNT_W  edge count from the most recent completed window.
REQ-012 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 early  output  1  run ended on the tolerance match; see Configuration.

Function
REQ-015 The FSM SHALL use states IDLE, SETTLE, MEASURE, DECIDE and DONE, and SHALL perform successive approximation, MSB first.
REQ-016 IDLE with start=1 SHALL set bit_idx=CODE_W-1, trim_code={1,0..0} and early=0, and go to SETTLE.
REQ-017 IDLE with start=0 SHALL hold trim_code and meas_count unchanged.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, ignore osc_edge, then go to MEASURE with the window counter and edge accumulator cleared.
REQ-019 MEASURE SHALL last exactly total_count+1 cycles; total_count=0 gives a 1-cycle window.
REQ-020 In MEASURE, each cycle with osc_edge=1 SHALL increment the accumulator, saturating at 2^CNT_W-1 with no wrap.
REQ-021 On leaving MEASURE, the accumulator SHALL be copied to meas_count.
REQ-022 DECIDE SHALL last 1 cycle: if meas_count > target_count, trim_code[bit_idx] SHALL be cleared, otherwise kept.
REQ-023 In DECIDE, if bit_idx==0 the FSM SHALL go to DONE; otherwise it SHALL decrement bit_idx, set trim_code[bit_idx-1] and go to SETTLE.
REQ-024 The final code SHALL be the largest code whose measured count is <= target_count, assuming monotonic oscillator response; it SHALL be 0 if every trial exceeds the target.
REQ-025 DONE SHALL assert done for 1 cycle with busy=0, then return to IDLE; trim_code and meas_count SHALL hold until the next accepted start.
REQ-026 start asserted while not in IDLE SHALL be ignored; start held high in DONE SHALL NOT be accepted until the IDLE cycle that follows.
REQ-027 total_count and target_count SHALL be sampled live each cycle and SHALL be held stable by the user while busy; behaviour is undefined if they change.
REQ-028 A full run SHALL take CODE_W*(SETTLE_CYC+total_count+2) busy cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, trim_code=0, meas_count=0, busy=0, done=0, early=0, bit_idx=CODE_W-1, and clear all internal counters.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release SHALL begin a fresh search.

Configuration
REQ-031 With macro CS_TRIM_TOL_EN defined, an input tol [3:0] SHALL exist.
REQ-032 With CS_TRIM_TOL_EN defined, in DECIDE, if |meas_count-target_count| <= tol, the trial bit SHALL be kept, early SHALL be set to 1, and the FSM SHALL go directly to DONE.
REQ-033 With CS_TRIM_TOL_EN undefined, port tol SHALL be absent, early SHALL be constant 0, and every run SHALL complete all CODE_W iterations.

Verification
REQ-034 Defaults, total_count=99, osc model gives 2*code edges/window, target=50 -> done after 630 busy cycles, trim_code=25, meas_count=50.
REQ-035 Same model, target=0 -> trim_code=0; target=4095 -> trim_code=63.
REQ-036 osc_edge tied high, total_count=255, CNT_W=8 -> meas_count saturates at 255, no wrap.
REQ-037 rst_n pulsed low during the 3rd MEASURE -> all outputs 0 immediately, no done; a new start yields the correct result.
REQ-038 CS_TRIM_TOL_EN defined, tol=2, target=33, 2*code model -> first trial 64 rejected, code 16 (32 edges) within tol -> early=1, done after 2 iterations, trim_code=16.
REQ-039 start pulsed during busy and held high through DONE -> no restart until the IDLE cycle; exactly one done per accepted start.
